// File: rtl/param_select_scan.sv
// param_select_scan: registered N-channel selector.
// Direct mode presents the channel given by num; auto-scan mode steps through
// every channel, staying DWELL cycles on each. out, sel_cur and wrap are all
// registered, so out always shows the data of the channel that sel_cur names.
module param_select_scan #(
    parameter int WIDTH = 4,
    parameter int CH    = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  hold,
    input  logic [SELW-1:0]       num,
    input  logic [CH*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]      out,
    output logic [SELW-1:0]       sel_cur,
    output logic                  wrap
);

    // The dwell counter is at least one bit wide so DWELL=1 still elaborates.
    localparam int              DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DLAST = DW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST  = SELW'(CH - 1);
    // One extra bit so CH = 2^SELW (e.g. 256 with SELW=8) compares correctly.
    localparam logic [SELW:0]   CH_V  = (SELW + 1)'(CH);

    logic [DW-1:0]    dcnt;
    logic [DW-1:0]    next_dcnt;
    logic [SELW-1:0]  next_sel;
    logic             next_wrap;
    logic [WIDTH-1:0] next_out;

    // Next channel, dwell count and wrap flag from the mode/hold rules.
    always_comb begin
        next_sel  = sel_cur;
        next_dcnt = '0;
        next_wrap = 1'b0;
        if (!mode) begin
            // An out-of-range num keeps the previous index.
            if ({1'b0, num} < CH_V) begin
                next_sel = num;
            end
        end else if (hold) begin
            next_dcnt = dcnt;
        end else if (dcnt == DLAST) begin
            next_sel  = (sel_cur == LAST) ? '0 : sel_cur + 1'b1;
            next_wrap = (sel_cur == LAST);
        end else begin
            next_dcnt = dcnt + 1'b1;
        end
    end

    // Pick the data of next_sel from the flattened channel bus.
    always_comb begin
        next_out = '0;
        for (int k = 0; k < CH; k++) begin
            if (next_sel == SELW'(k)) begin
                next_out = data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Register everything together so out and sel_cur never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            sel_cur <= '0;
            dcnt    <= '0;
            wrap    <= 1'b0;
        end else begin
            out     <= next_out;
            sel_cur <= next_sel;
            dcnt    <= next_dcnt;
            wrap    <= next_wrap;
        end
    end

endmodule

// File: tb/tb_param_select_scan.sv
// Bench for param_select_scan: two instances (CH=6/DWELL=3 and CH=8/DWELL=1)
// share the control inputs and are compared against a time-based model.
module tb_param_select_scan;

    localparam int WA = 4, CA = 6, DA = 3;
    localparam int WB = 5, CB = 8, DB = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic            hold;
    logic [2:0]      num;
    logic [CA*WA-1:0] data_a;
    logic [CB*WB-1:0] data_b;
    logic [WA-1:0]   out_a;
    logic [WB-1:0]   out_b;
    logic [2:0]      sel_a, sel_b;
    logic            wrap_a, wrap_b;

    int n_cmp = 0;
    int n_err = 0;

    param_select_scan #(.WIDTH(WA), .CH(CA), .SELW(3), .DWELL(DA)) u_a (
        .clk(clk), .rst(rst), .mode(mode), .hold(hold), .num(num),
        .data(data_a), .out(out_a), .sel_cur(sel_a), .wrap(wrap_a)
    );

    param_select_scan #(.WIDTH(WB), .CH(CB), .SELW(3), .DWELL(DB)) u_b (
        .clk(clk), .rst(rst), .mode(mode), .hold(hold), .num(num),
        .data(data_b), .out(out_b), .sel_cur(sel_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    // Model: in scan, the channel is start + (elapsed scan cycles / DWELL) mod CH.
    int chs[2] = '{CA, CB};
    int dws[2] = '{DA, DB};
    int m_sel[2], m_start[2], m_t[2], m_out[2], m_wrap[2];

    int cyc = 0;
    int last_wrap[2];
    bit period_en = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int chan(input int i, input int s);
        if (i == 0) return int'(data_a[s*WA +: WA]);
        return int'(data_b[s*WB +: WB]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 0; m_start[i] = 0; m_t[i] = 0; m_out[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_sel[i] = 0; m_start[i] = 0; m_t[i] = 0; m_wrap[i] = 0;
                m_out[i] = 0;
                continue;
            end
            if (!mode) begin
                if (int'(num) < chs[i]) m_sel[i] = int'(num);
                m_start[i] = m_sel[i];
                m_t[i] = 0;
                m_wrap[i] = 0;
            end else if (hold) begin
                m_wrap[i] = 0;
            end else begin
                m_t[i]++;
                m_sel[i] = (m_start[i] + m_t[i] / dws[i]) % chs[i];
                m_wrap[i] = ((m_t[i] % dws[i]) == 0 && m_sel[i] == 0) ? 1 : 0;
            end
            m_out[i] = chan(i, m_sel[i]);
        end
    endtask

    task automatic compare_all();
        check("a_out",  int'(out_a),  m_out[0]);
        check("a_sel",  int'(sel_a),  m_sel[0]);
        check("a_wrap", int'(wrap_a), m_wrap[0]);
        check("b_out",  int'(out_b),  m_out[1]);
        check("b_sel",  int'(sel_b),  m_sel[1]);
        check("b_wrap", int'(wrap_b), m_wrap[1]);
    endtask

    // One clock: model sees the pre-edge inputs, outputs are sampled 1ns after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (period_en) begin
            if (wrap_a) begin
                if (last_wrap[0] >= 0) check("a_wrap_period", cyc - last_wrap[0], CA*DA);
                last_wrap[0] = cyc;
            end
            if (wrap_b) begin
                if (last_wrap[1] >= 0) check("b_wrap_period", cyc - last_wrap[1], CB*DB);
                last_wrap[1] = cyc;
            end
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < CA; k++) data_a[k*WA +: WA] = WA'($urandom);
        for (int k = 0; k < CB; k++) data_b[k*WB +: WB] = WB'($urandom);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0; num = '0;
        for (int k = 0; k < CA; k++) data_a[k*WA +: WA] = WA'(k + 3);
        for (int k = 0; k < CB; k++) data_b[k*WB +: WB] = WB'(k + 3);
        model_reset();

        // Reset state
        step();
        step();
        check("rst_out_a", int'(out_a), 0);
        check("rst_sel_b", int'(sel_b), 0);

        // Direct sweep, including out-of-range indices 6 and 7 for instance a
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            num = 3'(n);
            step();
        end
        check("sweep_b_out_num7", int'(out_b), 7 + 3);

        // Out-of-range keeps index 2 while its data still refreshes
        num = 3'd2; step();
        num = 3'd7; step();
        data_a[2*WA +: WA] = 4'd9; step();
        check("oor_sel", int'(sel_a), 2);
        check("oor_out", int'(out_a), 9);

        // Scan from reset with wrap-period tracking
        rst = 1'b1; step();
        rst = 1'b0; mode = 1'b1;
        last_wrap[0] = -1; last_wrap[1] = -1; period_en = 1;
        for (int c = 0; c < 60; c++) step();
        period_en = 0;

        // Hold freezes the scan
        hold = 1'b1;
        for (int c = 0; c < 5; c++) step();
        hold = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // Direct -> scan from channel 5 -> back to direct
        mode = 1'b0; num = 3'd5; step();
        mode = 1'b1;
        for (int c = 0; c < 8; c++) step();
        mode = 1'b0; num = 3'd1; step();
        check("back_to_direct", int'(sel_a), 1);

        // Asynchronous reset between edges mid-scan
        mode = 1'b1;
        for (int c = 0; c < 7; c++) step();
        #2 rst = 1'b1;
        #1;
        check("async_out_a", int'(out_a), 0);
        check("async_sel_a", int'(sel_a), 0);
        check("async_sel_b", int'(sel_b), 0);
        check("async_wrap_b", int'(wrap_b), 0);
        model_reset();
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            hold = ($urandom_range(0, 5) == 0);
            num  = 3'($urandom);
            if ($urandom_range(0, 2) == 0) rand_data();
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
